// File: rtl/alu_serial.sv
// ---------------------------------------------------------------------------
// alu_serial -- bit-serial ALU (AND / OR / ADD / SLT), one bit per clock,
// LSB first, through a 1-bit slice with a carry flip-flop.
//
// Optional feature macro: ALU_SERIAL_FLAGS_EN
//   defined   -> zero / overflow flags are computed and registered
//   undefined -> zero / overflow ports exist but are tied to 0
//
// Parameters:
//   WIDTH     operand / result width in bits (>= 2)
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   start     request, sampled only in IDLE
//   a, b      operands
//   ainvert   invert all bits of A before the operation
//   binvert   invert all bits of B before the operation
//   cin       carry into bit 0
//   s1, s0    op select: 00 AND, 01 OR, 10 ADD, 11 SLT
//   busy      high while in RUN
//   done      one-cycle completion pulse (high in DONE)
//   x         registered result
//   cout      carry out of MSB (ADD/SLT only, else 0)
//   zero      x == 0
//   overflow  signed overflow of the ADD/SLT sum (else 0)
// ---------------------------------------------------------------------------
module alu_serial #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ainvert,
   input  logic             binvert,
   input  logic             cin,
   input  logic             s1,
   input  logic             s0,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x,
   output logic             cout,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_x;
   logic             r_ainv;
   logic             r_binv;
   logic             r_carry;
   logic             r_s1;
   logic             r_s0;
   logic             r_cout;

   logic             w_ai;
   logic             w_bi;
   logic             w_sum;
   logic             w_carry_out;
   logic             w_bit;
   logic             w_last;
   logic             w_ovf;
   logic             w_set;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_x_next;

   // Operands are shifted right every RUN cycle, so bit 0 is always the
   // current bit position.
   assign w_ai        = r_a[0] ^ r_ainv;
   assign w_bi        = r_b[0] ^ r_binv;
   assign w_sum       = w_ai ^ w_bi ^ r_carry;
   assign w_carry_out = (w_ai & w_bi) | (r_carry & (w_ai ^ w_bi));
   assign w_last      = (r_count == CW'(WIDTH - 1));

   // Only meaningful on the MSB cycle: carry into MSB xor carry out of MSB.
   assign w_ovf       = r_carry ^ w_carry_out;
   assign w_set       = w_sum ^ w_ovf;

   always_comb begin
      w_bit = 1'b0;
      unique case ({r_s1, r_s0})
         2'b00:   w_bit = w_ai & w_bi;
         2'b01:   w_bit = w_ai | w_bi;
         default: w_bit = w_sum;
      endcase
   end

   // Result bits enter at the top and walk down, so after WIDTH shifts
   // bit 0 of the accumulator holds result bit 0.
   assign w_acc_next = {w_bit, r_acc[WIDTH-1:1]};
   assign w_x_next   = (r_s1 & r_s0) ? {{(WIDTH-1){1'b0}}, w_set} : w_acc_next;

   // Next-state and decoded outputs
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_x     <= '0;
         r_ainv  <= 1'b0;
         r_binv  <= 1'b0;
         r_s1    <= 1'b0;
         r_s0    <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_ainv  <= ainvert;
                  r_binv  <= binvert;
                  r_carry <= cin;
                  r_s1    <= s1;
                  r_s0    <= s0;
                  r_count <= '0;
                  r_acc   <= '0;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_carry_out;
               r_acc   <= w_acc_next;
               if (w_last) begin
                  r_count <= '0;
                  r_x     <= w_x_next;
                  r_cout  <= r_s1 & w_carry_out;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign x    = r_x;
   assign cout = r_cout;

`ifdef ALU_SERIAL_FLAGS_EN
   logic r_zero;
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b1;
         r_ovf  <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         r_zero <= (w_x_next == '0);
         r_ovf  <= r_s1 & w_ovf;
      end
   end

   assign zero     = r_zero;
   assign overflow = r_ovf;
`else
   assign zero     = 1'b0;
   assign overflow = 1'b0;
`endif

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: ainvert  input  1  invert every bit of A before the operation.
REQ-008 Port: binvert  input  1  invert every bit of B before the operation.
REQ-009 Port: cin  input  1  carry into bit 0.
REQ-010 Port: s1, s0  input  1 each  op select: 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-011 Port: busy  output  1  high while in RUN.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: x  output  WIDTH  registered result.
REQ-014 Port: cout  output  1  carry out of MSB.
REQ-015 Port: zero  output  1  high when x == 0.
REQ-016 Port: overflow  output  1  signed overflow of the ADD/SLT sum.

Function
REQ-017 FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-018 On the start-sampling edge the block SHALL capture a, b, ainvert, binvert, cin, s1, s0; later input changes SHALL NOT affect the operation.
REQ-019 RUN SHALL process one bit per cycle, LSB first, through a 1-bit slice, using a bit counter 0..WIDTH-1 and a carry flip-flop preset to captured cin.
REQ-020 Per bit: ai = a[i]^ainvert, bi = b[i]^binvert; AND -> ai&bi; OR -> ai|bi; ADD/SLT sum -> ai^bi^carry.
REQ-021 SLT SHALL yield x = {WIDTH-1 zeros, set}, set = MSB of sum XOR overflow.
REQ-022 cout and overflow (carry into MSB XOR carry out of MSB) SHALL be valid for ADD/SLT and SHALL be 0 for AND/OR.
REQ-023 x, cout, zero, overflow SHALL update on the edge entering DONE and hold until the next DONE entry or reset.
REQ-024 done SHALL be high exactly one cycle, asserted WIDTH edges after the start-sampling edge.
REQ-025 start while busy or in DONE SHALL be ignored; no queuing.
REQ-026 Counter wrap SHALL occur only on RUN->DONE; count SHALL be 0 on every RUN entry.

Reset
REQ-027 rst SHALL force IDLE, busy=0, done=0, x=0, cout=0, zero=1, overflow=0, counter=0, carry=0 on the next edge.
REQ-028 rst SHALL take priority over start; rst mid-RUN SHALL abort with no done pulse and no update of x.

Configuration
REQ-029 Macro ALU_SERIAL_FLAGS_EN: defined -> zero and overflow behave per REQ-015/016/022; undefined -> zero and overflow ports SHALL exist but be tied 0 and no flag logic SHALL be synthesised.

Verification (WIDTH=8, ALU_SERIAL_FLAGS_EN defined)
REQ-030 AND: a=F0, b=3C, s=00 -> done exactly 8 cycles after start edge, x=30, cout=0, zero=0.
REQ-031 ADD: a=7F, b=01, cin=0, s=10 -> x=80, cout=0, overflow=1.
REQ-032 SUB: a=05, b=05, binvert=1, cin=1, s=10 -> x=00, cout=1, zero=1, overflow=0.
REQ-033 SLT: a=FE, b=03, binvert=1, cin=1, s=11 -> x=01, overflow=0.
REQ-034 NOR: a=0F, b=30, ainvert=1, binvert=1, s=00 -> x=C0; new start pulsed during busy -> ignored, single done.
REQ-035 rst on 4th RUN cycle -> next cycle busy=0, done never pulses, x=00, zero=1; fresh start afterwards completes normally.
